// File: rtl/oai_capture_pkg.sv
// Shared definitions for the OAI result capture stage.
//   WIDTH  : result vector width (netlist C port)
//   SLICE  : bits per netlist slice
//   NSLICE : number of complete slices (bit WIDTH-1 = 40 is outside all slices)
//   oai_entry_t : FIFO payload, result word plus its change mask
//   slice_chg   : per-slice difference mask between two result words
package oai_capture_pkg;

    localparam int unsigned WIDTH  = 41;
    localparam int unsigned SLICE  = 4;
    localparam int unsigned NSLICE = WIDTH / SLICE;

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [NSLICE-1:0] chg;
    } oai_entry_t;

    // Flags every complete slice whose bits differ; leftover high bits are ignored
    function automatic logic [NSLICE-1:0] slice_chg(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [NSLICE-1:0] m;
        m = '0;
        for (int k = 0; k < int'(NSLICE); k++) begin
            m[k] = |(a[k*SLICE +: SLICE] ^ b[k*SLICE +: SLICE]);
        end
        return m;
    endfunction

endpackage

// File: rtl/oai_capture_fifo.sv
// Show-ahead FIFO of oai_entry_t with wrap-bit pointers.
// Ports:
//   clk, rst       : rising-edge clock, async active-high reset (clears all entries)
//   i_push/i_wdata : write request and payload (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_rdata        : head entry, read combinationally
//   o_full/o_empty : occupancy flags
//   o_level        : number of stored entries
module oai_capture_fifo
    import oai_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  oai_entry_t               i_wdata,
    input  logic                     i_pop,
    output oai_entry_t               o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    oai_entry_t        r_mem [DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic              w_do_push;
    logic              w_do_pop;

    // Full when the pointers differ only in the wrap bit
    assign o_empty   = (r_wp == r_rp);
    assign o_full    = ((r_wp ^ r_rp) == {1'b1, {AW{1'b0}}});
    assign o_level   = r_wp - r_rp;
    assign o_rdata   = r_mem[r_rp[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage and pointers; all entries cleared so the head reads zero in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wp[AW-1:0]] <= i_wdata;
                r_wp                <= r_wp + PW'(1);
            end
            if (w_do_pop) begin
                r_rp <= r_rp + PW'(1);
            end
        end
    end

endmodule

// File: rtl/oai_result_capture.sv
// Capture stage for the OAI222 slice netlist C result vector.
// Queues each accepted word with a mask of the slices that changed since the
// previously accepted word.
// Optional feature macro: OAI_CAPTURE_PARITY_EN adds out_par (per-slice
// even parity of the head word, combinational, not stored).
// Ports:
//   clk, rst            : rising-edge clock, async active-high reset
//   in_c/in_valid       : result word from the netlist and its valid
//   in_ready            : word accepted this cycle when in_valid is high
//   out_data/out_chg    : head word and its change mask
//   out_par             : head per-slice parity (macro builds only)
//   out_valid/out_ready : head valid and consumer take
//   level               : current occupancy
module oai_result_capture
    import oai_capture_pkg::*;
#(
    parameter int unsigned WIDTH  = oai_capture_pkg::WIDTH,
    parameter int unsigned SLICE  = oai_capture_pkg::SLICE,
    parameter int unsigned NSLICE = WIDTH / SLICE,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_c,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [NSLICE-1:0]      out_chg,
`ifdef OAI_CAPTURE_PARITY_EN
    output logic [NSLICE-1:0]      out_par,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level
);

    logic [WIDTH-1:0] r_ref;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    oai_entry_t       w_wentry;
    oai_entry_t       w_head;

    assign in_ready  = !w_full && !rst;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_wentry.data = in_c;
    assign w_wentry.chg  = slice_chg(in_c, r_ref);

    assign out_data = w_head.data;
    assign out_chg  = w_head.chg;

    // Reference word: last accepted input, zero after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref <= '0;
        end else if (w_push) begin
            r_ref <= in_c;
        end
    end

    oai_capture_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

`ifdef OAI_CAPTURE_PARITY_EN
    // Per-slice parity of the head word
    always_comb begin
        out_par = '0;
        for (int k = 0; k < int'(NSLICE); k++) begin
            out_par[k] = ^out_data[k*SLICE +: SLICE];
        end
    end
`else
    // No parity output in this build
`endif

endmodule

// File: tb/tb_oai_result_capture.sv
// Directed bench for oai_result_capture: reset, change mask, fill and
// backpressure, streaming wrap, reset mid-operation, optional parity.
module tb_oai_result_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [40:0] in_c;
    logic        in_valid;
    logic        in_ready;
    logic [40:0] out_data;
    logic [9:0]  out_chg;
`ifdef OAI_CAPTURE_PARITY_EN
    logic [9:0]  out_par;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    oai_result_capture dut (
        .clk       (clk),
        .rst       (rst),
        .in_c      (in_c),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chg   (out_chg),
`ifdef OAI_CAPTURE_PARITY_EN
        .out_par   (out_par),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_c      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_chg", 64'(out_chg), 64'(0));

        rst = 1'b0;
        tick();
        chk("rel_in_ready", 64'(in_ready), 64'(1));
        chk("rel_level", 64'(level), 64'(0));

        // First word against zero reference
        in_valid = 1'b1;
        in_c     = 41'h0_0000_000F;
        tick();
        in_valid = 1'b0;
        chk("first_valid", 64'(out_valid), 64'(1));
        chk("first_data", 64'(out_data), 64'h0F);
        chk("first_chg", 64'(out_chg), 64'b0000000001);
        chk("first_level", 64'(level), 64'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("first_pop_level", 64'(level), 64'(0));
        chk("first_pop_valid", 64'(out_valid), 64'(0));

        // Change mask: identical word, then slices 0/1 plus bit 40
        in_valid = 1'b1;
        in_c     = 41'h0_0000_000F;
        tick();
        chk("same_chg", 64'(out_chg), 64'(0));
        in_c = 41'h100_0000_00F0;
        tick();
        in_valid = 1'b0;
        chk("chg_level2", 64'(level), 64'(2));
        out_ready = 1'b1;
        tick();
        chk("chg_data", 64'(out_data), 64'h100_0000_00F0);
        chk("chg_mask", 64'(out_chg), 64'b0000000011);
        tick();
        out_ready = 1'b0;
        chk("chg_drained", 64'(level), 64'(0));

        // Fill and backpressure
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_c = 41'(i);
            tick();
        end
        chk("fill_level", 64'(level), 64'(4));
        chk("fill_in_ready", 64'(in_ready), 64'(0));
        chk("fill_head", 64'(out_data), 64'(1));
        chk("fill_head_chg", 64'(out_chg), 64'b0000000011);
        in_c = 41'(5);
        tick();
        chk("stall_level", 64'(level), 64'(4));
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("popfull_level", 64'(level), 64'(3));
        chk("popfull_head", 64'(out_data), 64'(2));
        chk("popfull_in_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        chk("w5_level", 64'(level), 64'(4));
        out_ready = 1'b1;
        for (int j = 2; j <= 5; j++) begin
            chk("drain_data", 64'(out_data), 64'(j));
            if (j == 5) chk("w5_chg", 64'(out_chg), 64'b0000000001);
            tick();
        end
        chk("drain_level", 64'(level), 64'(0));

        // Streaming with pointer wrap
        in_valid = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            in_c = 41'(i);
            tick();
            chk("stream_valid", 64'(out_valid), 64'(1));
            chk("stream_data", 64'(out_data), 64'(i));
            chk("stream_level", 64'(level), 64'(1));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("stream_end_level", 64'(level), 64'(0));

        // Reset mid-operation
        in_valid = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            in_c = 41'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_level", 64'(level), 64'(3));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_level", 64'(level), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        chk("mid_rst_data", 64'(out_data), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        in_c     = '0;
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", 64'(out_valid), 64'(1));
        chk("post_rst_chg", 64'(out_chg), 64'(0));
        chk("post_rst_level", 64'(level), 64'(1));

`ifdef OAI_CAPTURE_PARITY_EN
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_c      = 41'h0_0000_0007;
        tick();
        in_valid = 1'b0;
        chk("par_data", 64'(out_data), 64'h7);
        chk("par_mask", 64'(out_par), 64'b0000000001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/oai_result_capture.md
# oai_result_capture

Downstream capture stage for the 41-bit `C` result vector of the flattened INV/OAI222 slice netlist. It registers each presented result word into a small FIFO with a valid/ready handshake. Alongside each word it stores a per-4-bit-slice change mask, which flags the slices that differ from the previously accepted word. It isolates the combinational netlist from the slower consumer, and the sampled words serve as a stable observation point for netlist equivalence runs.

## Interface
Parameters:
- `WIDTH`, default 41: result vector width. Matches the netlist `C` port.
- `SLICE`, default 4: bits per netlist slice.
- `NSLICE`, default `WIDTH/SLICE` = 10: number of complete slices, covering bits 0..39. Bit 40 is carried in the data but belongs to no slice.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`, input, 1: sole clock. All logic is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_c`, input, `WIDTH`: result vector from the netlist `C` output.
- `in_valid`, input, 1: `in_c` is presented.
- `in_ready`, output, 1: stage accepts a word this cycle.
- `out_data`, output, `WIDTH`: head-of-FIFO result word.
- `out_chg`, output, `NSLICE`: head-of-FIFO change mask. Bit k=1 means slice k differs from the previously accepted word.
- `out_par`, output, `NSLICE`: per-slice even parity of `out_data`. Present only with the macro (see Configuration).
- `out_valid`, output, 1: head entry valid.
- `out_ready`, input, 1: consumer takes the head entry.
- `level`, output, `$clog2(DEPTH)+1`: current occupancy.

## Operation
- Push: occurs when `in_valid && in_ready` at a rising edge. It writes `{in_c, chg}` at the write pointer, advances the write pointer, and updates the reference register `ref_q <= in_c`.
- Change mask: `chg[k] = |(in_c[k*SLICE +: SLICE] ^ ref_q[k*SLICE +: SLICE])`. Bit 40 does not contribute.
- Pop: occurs when `out_valid && out_ready` at a rising edge. It advances the read pointer.
- FIFO organisation: show-ahead. `out_data`, `out_chg` and `out_par` are read combinationally from the head entry.
- Pointers: `$clog2(DEPTH)+1` bits, using an extra wrap bit.
  - Empty is `wp == rp`.
  - Full is when the pointers differ only in the MSB.
  - Wrap-around is natural modulo 2·`DEPTH`.
- `in_ready = !full && !rst`. When full, a push is refused even if a pop happens in the same cycle. There is no pass-through.
- `out_valid = !empty`.
- Simultaneous push and pop when not full and not empty: both take effect and `level` is unchanged.
- Push into an empty FIFO: no bypass. The word appears on `out_valid` the cycle after it is accepted.
- Rejected cycles do not update `ref_q`. These are cycles with `in_valid` high and `in_ready` low.
- `in_c` is don't-care when `in_valid` is low. Nothing is sampled.

## Timing
- Reset values, asserted asynchronously:
  - `out_valid=0`, `in_ready=0`, `level=0`.
  - Pointers 0, `ref_q=0`.
  - `out_data`, `out_chg` and `out_par` all zero, because the head entry is cleared. All storage entries are cleared on reset.
- Cycle after reset deassertion: `in_ready=1`.
- Latency from acceptance to visibility:
  - Word accepted at edge N: `out_valid=1` with that word after edge N.
  - `level` updates at the same edge as the push or pop.
- Throughput: one word per cycle sustained in both directions while 0 < `level` < `DEPTH`.
- Reset mid-operation: all queued entries are discarded and `ref_q` returns to 0. The first word after reset is compared against zero.

## Configuration
- `OAI_CAPTURE_PARITY_EN` defined: `out_par` port exists. `out_par[k]` is the XOR of slice k of `out_data`, computed combinationally from the head entry and not stored.
- `OAI_CAPTURE_PARITY_EN` undefined: the `out_par` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `oai_capture_pkg` holds:
  - `localparam` defaults `WIDTH`, `SLICE`, `NSLICE`.
  - typedef `oai_entry_t`: a packed struct of data and chg.
  - function `slice_chg(a, b)` returning the `NSLICE` change mask.
- One natural sub-module, `oai_capture_fifo`: generic `DEPTH` × `oai_entry_t` storage with pointers, full/empty and level.
- The top level holds `ref_q`, the change-mask computation and the optional parity.

## Test plan
- Reset release: after reset, `level=0`, `out_valid=0`, and `in_ready` is 0 during reset and 1 on the cycle after release. Then push `in_c=41'h0_0000_000F` → `out_data=41'h0000000000F`, `out_chg=10'b0000000001`.
- Change mask: push `41'h0000000000F` then `41'h100000000F0`. The second entry's mask is `out_chg=10'b0000000011`; bit 40 is ignored.
- Fill and backpressure:
  - Hold `out_ready=0` and push 5 words. Words 1–4 are accepted, `level=4` and `in_ready=0`; word 5 stalls.
  - Raise `out_ready` for one cycle with `in_valid` high → one pop and no push that cycle, `level=3`. The next cycle word 5 is accepted.
- Streaming wrap: push 12 words 1..12 with `out_ready=1` continuously → words are output in order, `level` stays ≤1, and the pointers wrap with no loss or duplication.
- Reset mid-operation: with `level=3`, assert `rst` → `out_valid` drops immediately. After release, pushing `41'h0` gives `out_chg=0`.
- With `OAI_CAPTURE_PARITY_EN`: push `41'h0_0000_0007` → `out_par=10'b0000000001`.
